// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default bus width and occupancy count type.
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 32;

  typedef logic [1:0] count_t;

  function automatic count_t occupancy(input logic main_full, input logic skid_full);
    return count_t'(main_full) + count_t'(skid_full);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One data entry of the pipeline stage: WIDTH-bit register with async reset,
// synchronous clear (priority over load) and load enable.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = RESET_VAL;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with registered output data.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready;
// otherwise a single entry with combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output count_t           count
);

  logic accept;
  logic retire;

`ifdef PIPE_STAGE_SKID_EN
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             main_load, skid_load;
  logic [WIDTH-1:0] main_src, main_data, skid_data;

  assign accept = in_valid && in_ready_q;
  assign retire = main_valid_q && out_ready;

  // Main refills from skid first; skid only fills while main is stalled.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_src     = in_data;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || retire) begin
      if (skid_valid_q) begin
        main_load    = 1'b1;
        main_src     = skid_data;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_load    = accept;
        main_valid_d = accept;
      end
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  pipe_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clock (clock),
    .rst   (rst),
    .clr   (flush),
    .load  (main_load),
    .d     (main_src),
    .q     (main_data)
  );

  pipe_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clock (clock),
    .rst   (rst),
    .clr   (flush),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data;
  assign count     = occupancy(main_valid_q, skid_valid_q);
`else
  logic valid_q, valid_d;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (retire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  pipe_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clock (clock),
    .rst   (rst),
    .clr   (flush),
    .load  (accept),
    .d     (in_data),
    .q     (out_data)
  );

  assign out_valid = valid_q;
  assign count     = occupancy(valid_q, 1'b0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg at WIDTH 32, 1 and 64.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [63:0] RV64 = 64'hFFFF_0000_FFFF_0000;

  logic        clock;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        d1;
  logic [63:0] d64;

  logic        o_ready, o_valid;
  logic [31:0] o_data;
  count_t      o_count;
  logic        o1_ready, o1_valid;
  logic        o1_data;
  count_t      o1_count;
  logic        o64_ready, o64_valid;
  logic [63:0] o64_data;
  count_t      o64_count;

  logic [31:0] q[$];
  logic        q1[$];
  logic [63:0] q64[$];

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg dut (
    .clock(clock), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ready),
    .in_data(in_data), .out_valid(o_valid), .out_ready(out_ready), .out_data(o_data),
    .count(o_count)
  );

  pipe_stage_reg #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clock(clock), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_ready),
    .in_data(d1), .out_valid(o1_valid), .out_ready(out_ready), .out_data(o1_data),
    .count(o1_count)
  );

  pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RV64)) dut64 (
    .clock(clock), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o64_ready),
    .in_data(d64), .out_valid(o64_valid), .out_ready(out_ready), .out_data(o64_data),
    .count(o64_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd1);
    chk({tag, "_data"}, 64'(o_data), (q.size() > 0) ? 64'(q[0]) : 'x);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic        w1  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [63:0] w64 [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
                           64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; d1 = 1'b0; d64 = '0;

    // Reset state before any clock edge
    #2;
    chk("rst_out_valid", 64'(o_valid), 64'd0);
    chk("rst_out_data", 64'(o_data), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_in_ready", 64'(o_ready), 64'd1);
    chk("rst_data64", o64_data, RV64);
    #10 rst = 1'b0;

    // First edge after reset accepts; then async reset mid-cycle drops it
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    chk("first_count", 64'(o_count), 64'd1);
    head("first");
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(o_valid), 64'd0);
    chk("midrst_out_data", 64'(o_data), 64'd0);
    chk("midrst_count", 64'(o_count), 64'd0);
    chk("midrst_in_ready", 64'(o_ready), 64'd1);
    chk("midrst_data64", o64_data, RV64);
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    tick();
    chk("post_rst_no_word", 64'(o_valid), 64'd0);

    // Streaming 1..4 with out_ready held high
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
      q.push_back(in_data);
      tick();
      chk("stream_count", 64'(o_count), 64'd1);
      head("stream");
      void'(q.pop_front());
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 64'(o_valid), 64'd0);
    chk("stream_drain_count", 64'(o_count), 64'd0);

    // Stall with 0xA, 0xB offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; q.push_back(in_data);
    tick();
    chk("stall_a_count", 64'(o_count), 64'd1);
    head("stall_a");
    in_data = 32'hB;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("stall_skid_ready", 64'(o_ready), 64'd1);
    q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    chk("stall_count", 64'(o_count), 64'd2);
    chk("stall_in_ready", 64'(o_ready), 64'd0);
    head("stall_hold");
    out_ready = 1'b1;
    void'(q.pop_front());
    tick();
    chk("stall_b_count", 64'(o_count), 64'd1);
    head("stall_b");
    void'(q.pop_front());
    tick();
`else
    chk("stall_in_ready_comb", 64'(o_ready), 64'd0);
    tick();
    chk("stall_count", 64'(o_count), 64'd1);
    chk("stall_in_ready", 64'(o_ready), 64'd0);
    head("stall_hold");
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(o_ready), 64'd1);
    q.push_back(in_data);
    void'(q.pop_front());
    tick();
    in_valid = 1'b0;
    chk("stall_b_count", 64'(o_count), 64'd1);
    head("stall_b");
    void'(q.pop_front());
    tick();
`endif
    chk("stall_drain_valid", 64'(o_valid), 64'd0);

    // Flush with a simultaneous offered word and retire
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1; d64 = 64'h1234;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    in_data = 32'hC2;
    tick();
    chk("preflush_count", 64'(o_count), 64'd2);
`else
    chk("preflush_count", 64'(o_count), 64'd1);
`endif
    flush = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_data", 64'(o_data), 64'd0);
    chk("flush_data64", o64_data, RV64);
    chk("flush_count64", 64'(o64_count), 64'd0);
    tick();
    chk("flush_no_55", 64'(o_valid), 64'd0);

    // Simultaneous accept and retire at count 1
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3; q.push_back(in_data);
    tick();
    chk("ar_pre_count", 64'(o_count), 64'd1);
    head("ar_pre");
    in_data = 32'h7; out_ready = 1'b1;
    q.push_back(in_data);
    void'(q.pop_front());
    tick();
    in_valid = 1'b0;
    chk("ar_count", 64'(o_count), 64'd1);
    head("ar_post");
    void'(q.pop_front());
    tick();
    chk("ar_drain_valid", 64'(o_valid), 64'd0);
    chk("ar_drain_count", 64'(o_count), 64'd0);

    // Width extremes streaming, including all-ones words
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = 32'hFFFF_FFFF; d1 = w1[i]; d64 = w64[i];
      q.push_back(in_data); q1.push_back(d1); q64.push_back(d64);
      tick();
      head("w32");
      chk("w1_valid", 64'(o1_valid), 64'd1);
      chk("w1_data", 64'(o1_data), 64'(q1[0]));
      chk("w1_count", 64'(o1_count), 64'd1);
      chk("w64_valid", 64'(o64_valid), 64'd1);
      chk("w64_data", o64_data, q64[0]);
      chk("w64_count", 64'(o64_count), 64'd1);
      void'(q.pop_front()); void'(q1.pop_front()); void'(q64.pop_front());
    end
    in_valid = 1'b0;
    tick();
    chk("w_drain_valid1", 64'(o1_valid), 64'd0);
    chk("w_drain_valid64", 64'(o64_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
